tlp_tx_arbiter: RTL

Packet-granular round-robin arbiter that shares the single FPGA->Host TLP transmit pipe (64-bit data, SOP/EOP, valid/ready) between NUM_REQ requesters, e.g. completion generator and DMA write engine inside the PCIe application.
- Sits between those engines and the pcie_cv TX input.
- Once a requester is granted, it holds the pipe until its EOP beat is accepted, so TLPs never interleave.

---
 rtl/tlp_xcvr_pkg.sv | 16 +
 rtl/tlp_tx_arbiter_if.sv | 29 ++
 rtl/tlp_tx_arbiter_rr_pick.sv | 30 +++
 rtl/tlp_tx_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/tlp_xcvr_pkg.sv
// Shared TLP transceiver types: 64-bit beat word and the TX arbiter state encoding.
package tlp_xcvr_pkg;

    typedef logic [63:0] uint64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ArbState;

    // Width of an index into n requesters; never zero so single-bit ports stay legal.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tlp_tx_arbiter_if.sv
// Requester-side and PCIe-core-side TLP beat buses of the TX arbiter.
interface tlp_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import tlp_xcvr_pkg::*;

    uint64 [NUM_REQ-1:0] reqData_in;
    logic  [NUM_REQ-1:0] reqSOP_in;
    logic  [NUM_REQ-1:0] reqEOP_in;
    logic  [NUM_REQ-1:0] reqValid_in;
    logic  [NUM_REQ-1:0] reqReady_out;

    uint64               txData_out;
    logic                txSOP_out;
    logic                txEOP_out;
    logic                txValid_out;
    logic                txReady_in;

    modport master (
        input  reqData_in, reqSOP_in, reqEOP_in, reqValid_in, txReady_in,
        output reqReady_out, txData_out, txSOP_out, txEOP_out, txValid_out
    );

    modport slave (
        output reqData_in, reqSOP_in, reqEOP_in, reqValid_in, txReady_in,
        input  reqReady_out, txData_out, txSOP_out, txEOP_out, txValid_out
    );

endinterface

// File: rtl/tlp_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_i, wrapping.
module rr_pick
    import tlp_xcvr_pkg::*;
#(
    parameter  int N = 2,
    localparam int W = idxWidth(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    logic [W-1:0] cand;

    // Walk N positions starting one past last_i so last_i itself is checked last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = last_i;
        cand    = last_i;
        for (int k = 0; k < N; k++) begin
            cand = (cand == W'(N - 1)) ? '0 : cand + 1'b1;
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Packet-granular round-robin arbiter for the FPGA->Host TLP TX pipe.
// Optional per-requester packet counters with `define TLP_TX_ARB_STATS_EN.
module tlp_tx_arbiter
    import tlp_xcvr_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int GW      = idxWidth(NUM_REQ)
) (
    input  logic                      pcieClk_in,
    input  logic                      pcieRstN_in,
    tlp_tx_arbiter_if.master          bus,
    output logic [GW-1:0]             grant_out,
    output logic                      busy_out
`ifdef TLP_TX_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][31:0]  pktCount_out
`endif
);

    ArbState     state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic        pickFound;
    logic [GW-1:0] pickIdx;
    logic        eopXfer;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (bus.reqValid_in & bus.reqSOP_in),
        .last_i  (grant_q),
        .found_o (pickFound),
        .idx_o   (pickIdx)
    );

    always_ff @(posedge pcieClk_in) begin
        if (!pcieRstN_in) begin
            state_q <= IDLE;
            grant_q <= GW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Pass-through is also gated by reset so an in-flight beat is dropped at once.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        eopXfer          = 1'b0;
        bus.txData_out   = '0;
        bus.txSOP_out    = 1'b0;
        bus.txEOP_out    = 1'b0;
        bus.txValid_out  = 1'b0;
        bus.reqReady_out = '0;
        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    grant_d = pickIdx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (pcieRstN_in) begin
                    bus.txData_out            = bus.reqData_in[grant_q];
                    bus.txSOP_out             = bus.reqSOP_in[grant_q];
                    bus.txEOP_out             = bus.reqEOP_in[grant_q];
                    bus.txValid_out           = bus.reqValid_in[grant_q];
                    bus.reqReady_out[grant_q] = bus.txReady_in;
                end
                eopXfer = bus.reqValid_in[grant_q] & bus.txReady_in & bus.reqEOP_in[grant_q];
                if (eopXfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_out = grant_q;
    assign busy_out  = (state_q == BUSY);

`ifdef TLP_TX_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] pktCount_q;

    always_ff @(posedge pcieClk_in) begin
        if (!pcieRstN_in) begin
            pktCount_q <= '0;
        end else if (eopXfer) begin
            pktCount_q[grant_q] <= pktCount_q[grant_q] + 32'd1;
        end
    end

    assign pktCount_out = pktCount_q;
`endif

endmodule
